// File: rtl/nibble_serial_pkg.sv
// Shared definitions for the nibble-serial adder.
// Holds the slice width, the controller state encoding and sizing helpers.
package nibble_serial_pkg;

    // Width of the single combinational adder slice.
    localparam int NIB_W = 4;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slice cycles needed for an operand of the given width.
    function automatic int calc_nibbles(input int width);
        return width / NIB_W;
    endfunction

    // An operand width is legal if it is a whole, non-zero number of nibbles.
    function automatic bit width_ok(input int width);
        return (width >= NIB_W) && ((width % NIB_W) == 0);
    endfunction

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int calc_idx_w(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Purely combinational 4-bit ripple adder: sum_o = a_i + b_i + cin_i.
// This is the only adder hardware in the serial adder; it is reused once per nibble.
module nibble_add_slice
    import nibble_serial_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             cin_i,
    output logic [NIB_W-1:0] sum_o,
    output logic             cout_o
);

    // carry[k] is the carry into bit k; carry[NIB_W] leaves the slice.
    logic [NIB_W:0] carry;

    assign carry[0] = cin_i;

    // One full adder per bit, chained through carry.
    for (genvar gi = 0; gi < NIB_W; gi++) begin : g_bit
        assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ carry[gi];
        assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
    end

    assign cout_o = carry[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder built around a single 4-bit slice.
// Operands are accepted with a valid/ready handshake, added one nibble per
// cycle (carry kept in a flop between cycles), and the full sum plus carry-out
// are offered downstream with a second valid/ready handshake.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow port ovf.
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = calc_nibbles(WIDTH);
    localparam int IDX_W   = calc_idx_w(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    // Reject operand widths that are not a whole number of nibbles.
    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    // Control strobes from the FSM
    logic               accept;     // operand handshake completes this cycle
    logic               run_step;   // slice result is consumed this cycle
    logic               last_step;  // final nibble is being added
    logic [NIBBLES-1:0] nib_we;     // one-hot write enable into the sum register

    // Slice interface
    logic [NIB_W-1:0]   slice_a;
    logic [NIB_W-1:0]   slice_b;
    logic [NIB_W-1:0]   slice_sum;
    logic               slice_cout;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------

    // FSM state register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and handshake outputs. No accept in DONE, so a new
    // operation can only start once the previous result has been taken.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        run_step  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                run_step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign last_step = run_step && (idx_q == LAST_IDX);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Select the operand nibbles addressed by the current index.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[i*NIB_W +: NIB_W];
                slice_b = b_q[i*NIB_W +: NIB_W];
            end
        end
    end

    nibble_add_slice u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // Operand capture, carry chaining and nibble index sequencing.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        cout_d  = cout_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
            cout_d  = 1'b0;
        end else if (run_step) begin
            carry_d = slice_cout;
            if (last_step) begin
                idx_d  = '0;
                cout_d = slice_cout;
            end else begin
                idx_d  = idx_q + IDX_W'(1);
            end
        end
    end

    // Each sum nibble is cleared on accept and written once, in its own RUN cycle.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_sum_nib
        assign nib_we[gi] = run_step && (idx_q == IDX_W'(gi));
        assign sum_d[gi*NIB_W +: NIB_W] = accept     ? '0
                                        : nib_we[gi] ? slice_sum
                                        :              sum_q[gi*NIB_W +: NIB_W];
    end

    // Datapath registers; results hold unchanged through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: operands agree in sign but the result MSB (top bit of
    // the final slice sum) does not.
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if (last_step) begin
            ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[NIB_W-1] != a_q[WIDTH-1]);
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16).
// A transaction-level model predicts handshakes and results every cycle;
// directed sequences add hand-computed literal expectations.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: an accepted pair produces a+b+cin after
    // NIB cycles; the result is offered until taken, then the block is free.
    // ------------------------------------------------------------------
    bit           m_in_ready = 1'b1;
    bit           m_valid    = 1'b0;
    bit           m_busy     = 1'b0;
    int           m_wait     = 0;
    logic [W:0]   m_res      = '0;
    bit           m_ovf      = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_in_ready = 1'b1;
            m_valid    = 1'b0;
            m_busy     = 1'b0;
        end else if (m_in_ready && in_valid) begin
            longint s;
            m_res      = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            s          = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
            m_ovf      = (s > ((longint'(1) <<< (W-1)) - 1)) || (s < -(longint'(1) <<< (W-1)));
            m_in_ready = 1'b0;
            m_busy     = 1'b1;
            m_wait     = NIB;
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin
                m_busy  = 1'b0;
                m_valid = 1'b1;
            end
        end else if (m_valid && out_ready) begin
            m_valid    = 1'b0;
            m_in_ready = 1'b1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, m_in_ready);
            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("model_sum", sum, m_res[W-1:0]);
                check("model_cout", cout, m_res[W]);
`ifdef SERIAL_ADD_OVF_EN
                check("model_ovf", ovf, m_ovf);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int c = 0;
        while (!in_ready && c < 40) begin
            tick();
            c++;
        end
        check("wait_in_ready", in_ready, 1);
    endtask

    // One complete operation with out_ready held high; checks latency and result.
    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
        int lat = 0;
        wait_ready();
        out_ready = 1'b1;
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        check({name, "_latency"}, lat, NIB);
        check({name, "_sum"}, sum, es);
        check({name, "_cout"}, cout, ec);
`ifdef SERIAL_ADD_OVF_EN
        check({name, "_ovf"}, ovf, eo);
`endif
        $display("op %s: %h + %h + %0d -> sum %h cout %0d (ovf exp %0d) latency %0d",
                 name, ta, tb_, tc, sum, cout, eo, lat);
        tick();
        check({name, "_drop"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int c;
        int nres;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", ovf, 0);
`endif

        // Basic add and carry-chain boundaries
        run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("chain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

        // Backpressure: result must hold while out_ready is low
        wait_ready();
        out_ready = 1'b0;
        a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        c = 0;
        while (!out_valid && c < 40) begin
            tick();
            c++;
        end
        check("bp_latency", c, NIB);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_sum", sum, 16'h0000);
            check("bp_cout", cout, 1);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        $display("op backpressure: a5a5 + 5a5a + 1 held 6 cycles then released");

        // Reset in the middle of RUN
        wait_ready();
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        for (int i = 0; i < 6; i++) tick();
        check("midrst_no_result", out_valid, 0);
        $display("op midreset: 00ff + 0001 discarded");
        run_op("after_rst", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);

        // Back-to-back with operands changing every cycle
        wait_ready();
        out_ready = 1'b1;
        nres = 0;
        for (int k = 0; k < 18; k++) begin
            a = 16'h0F0F + 16'(k) * 16'h1111;
            b = (16'(k) * 16'h2222) ^ 16'hF0F1;
            cin = 1'(k % 2);
            in_valid = 1'b1;
            tick();
            if (out_valid) begin
                nres++;
                $display("op b2b #%0d: sum %h cout %0d", nres, sum, cout);
                if (nres == 1) begin
                    check("b2b_first_sum", sum, 16'h0000);
                    check("b2b_first_cout", cout, 1);
                end
                if (nres == 2) begin
                    check("b2b_second_sum", sum, 16'hB1B2);
                    check("b2b_second_cout", cout, 0);
                end
            end
        end
        in_valid = 1'b0;
        check("b2b_result_count", nres, 3);

`ifdef SERIAL_ADD_OVF_EN
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("ovf_none", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
`endif

        tick();
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
